// File: rtl/scr1_tapc_fsm_ctrl_if.sv
// DR control bus between the TAP controller and its attached data registers.
//   fsm_reset  : high while the TAP sits in Test-Logic-Reset (sync reset for DRs)
//   dr_select  : one-hot DR select, [0] IDCODE, [1] DTMCS, [2] DMI
//   dr_capture : TAP in Capture-DR
//   dr_shift   : TAP in Shift-DR
//   dr_update  : TAP in Update-DR
//   dr_tdo     : serial outputs of the DRs, same bit order as dr_select
// Strobe semantics: there is no valid/ready pair. Each strobe is a level that
// is high for exactly the TCK cycles the TAP spends in the matching state. A DR
// acts on the rising TCK edge only while its dr_select bit and a strobe are both
// high. dr_tdo is sampled by the TAP on the falling edge of every Shift-DR cycle.
interface scr1_tapc_fsm_ctrl_if;
  logic       fsm_reset;
  logic [2:0] dr_select;
  logic       dr_capture;
  logic       dr_shift;
  logic       dr_update;
  logic [2:0] dr_tdo;

  modport master (
    output fsm_reset, dr_select, dr_capture, dr_shift, dr_update,
    input  dr_tdo
  );

  modport slave (
    input  fsm_reset, dr_select, dr_capture, dr_shift, dr_update,
    output dr_tdo
  );
endinterface

// File: rtl/scr1_tapc_fsm_ctrl.sv
// JTAG TAP controller: IEEE 1149.1 16-state FSM, instruction register,
// instruction decode, internal bypass DR and the TDO mux.
// Ports:
//   clk       : TCK
//   rst_n     : TRST_n, asynchronous, active-low
//   tms, tdi  : JTAG inputs, sampled on rising TCK
//   tdo       : serial out, registered on falling TCK
//   tdo_en    : TDO output enable, registered on falling TCK
//   ir_value  : current (updated) instruction
//   fsm_state : current TAP state, for observation
//   dr_bus    : DR control strobes / DR serial returns (master side)
module scr1_tapc_fsm_ctrl #(
  parameter int unsigned         IR_WIDTH  = 5,
  parameter logic [IR_WIDTH-1:0] IDCODE_OP = 'h01,
  parameter logic [IR_WIDTH-1:0] DTMCS_OP  = 'h10,
  parameter logic [IR_WIDTH-1:0] DMI_OP    = 'h11
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                tms,
  input  logic                tdi,
  output logic                tdo,
  output logic                tdo_en,
  output logic [IR_WIDTH-1:0] ir_value,
  output logic [3:0]          fsm_state,
  scr1_tapc_fsm_ctrl_if.master dr_bus
);

  typedef enum logic [3:0] {
    TLR      = 4'd0,
    RTI      = 4'd1,
    SEL_DR   = 4'd2,
    CAP_DR   = 4'd3,
    SH_DR    = 4'd4,
    EX1_DR   = 4'd5,
    PAUSE_DR = 4'd6,
    EX2_DR   = 4'd7,
    UPD_DR   = 4'd8,
    SEL_IR   = 4'd9,
    CAP_IR   = 4'd10,
    SH_IR    = 4'd11,
    EX1_IR   = 4'd12,
    PAUSE_IR = 4'd13,
    EX2_IR   = 4'd14,
    UPD_IR   = 4'd15
  } tap_state_e;

  // Fixed pattern the IR presents in Capture-IR (LSB = 1 as 1149.1 requires).
  localparam logic [IR_WIDTH-1:0] IR_CAPTURE = IR_WIDTH'(1);

  tap_state_e          state, state_next;
  logic [IR_WIDTH-1:0] ir_shift;
  logic                bypass_reg;
  logic [2:0]          dr_sel;
  logic                tdo_next;
  logic                tdo_en_next;

  // ---------------------------------------------------------------- FSM
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= TLR;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      TLR:      state_next = tms ? TLR    : RTI;
      RTI:      state_next = tms ? SEL_DR : RTI;
      SEL_DR:   state_next = tms ? SEL_IR : CAP_DR;
      CAP_DR:   state_next = tms ? EX1_DR : SH_DR;
      SH_DR:    state_next = tms ? EX1_DR : SH_DR;
      EX1_DR:   state_next = tms ? UPD_DR : PAUSE_DR;
      PAUSE_DR: state_next = tms ? EX2_DR : PAUSE_DR;
      EX2_DR:   state_next = tms ? UPD_DR : SH_DR;
      UPD_DR:   state_next = tms ? SEL_DR : RTI;
      SEL_IR:   state_next = tms ? TLR    : CAP_IR;
      CAP_IR:   state_next = tms ? EX1_IR : SH_IR;
      SH_IR:    state_next = tms ? EX1_IR : SH_IR;
      EX1_IR:   state_next = tms ? UPD_IR : PAUSE_IR;
      PAUSE_IR: state_next = tms ? EX2_IR : PAUSE_IR;
      EX2_IR:   state_next = tms ? UPD_IR : SH_IR;
      UPD_IR:   state_next = tms ? SEL_DR : RTI;
      default:  state_next = TLR;
    endcase
  end

  assign fsm_state         = state;
  assign dr_bus.fsm_reset  = (state == TLR);
  assign dr_bus.dr_capture = (state == CAP_DR);
  assign dr_bus.dr_shift   = (state == SH_DR);
  assign dr_bus.dr_update  = (state == UPD_DR);

  // ---------------------------------------------------------------- IR
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ir_shift <= IR_CAPTURE;
    end else if (state == TLR || state == CAP_IR) begin
      ir_shift <= IR_CAPTURE;
    end else if (state == SH_IR) begin
      ir_shift <= {tdi, ir_shift[IR_WIDTH-1:1]};
    end
  end

  // Instruction changes on the falling edge so DRs see a stable select for
  // the whole following rising edge.
  always_ff @(negedge clk or negedge rst_n) begin
    if (!rst_n)                ir_value <= IDCODE_OP;
    else if (state == TLR)     ir_value <= IDCODE_OP;
    else if (state == UPD_IR)  ir_value <= ir_shift;
  end

  always_comb begin
    dr_sel = 3'b000;
    if      (ir_value == IDCODE_OP) dr_sel = 3'b001;
    else if (ir_value == DTMCS_OP)  dr_sel = 3'b010;
    else if (ir_value == DMI_OP)    dr_sel = 3'b100;
  end

  assign dr_bus.dr_select = dr_sel;

  // ---------------------------------------------------------------- bypass
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                 bypass_reg <= 1'b0;
    else if (state == CAP_DR)   bypass_reg <= 1'b0;
    else if (state == SH_DR)    bypass_reg <= tdi;
  end

  // ---------------------------------------------------------------- TDO
  // Unknown opcodes select no DR, so the bypass bit drives TDO.
  always_comb begin
    tdo_next    = 1'b0;
    tdo_en_next = 1'b0;
    case (state)
      SH_IR: begin
        tdo_next    = ir_shift[0];
        tdo_en_next = 1'b1;
      end
      SH_DR: begin
        tdo_next    = (dr_sel == 3'b000) ? bypass_reg : |(dr_sel & dr_bus.dr_tdo);
        tdo_en_next = 1'b1;
      end
      default: begin
        tdo_next    = 1'b0;
        tdo_en_next = 1'b0;
      end
    endcase
  end

  always_ff @(negedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tdo    <= 1'b0;
      tdo_en <= 1'b0;
    end else begin
      tdo    <= tdo_next;
      tdo_en <= tdo_en_next;
    end
  end

endmodule

// File: tb/tb_scr1_tapc_fsm_ctrl.sv
module tb_scr1_tapc_fsm_ctrl;

  localparam logic [3:0] ST_TLR      = 4'd0;
  localparam logic [3:0] ST_SH_DR    = 4'd4;
  localparam logic [3:0] ST_SH_IR    = 4'd11;
  localparam logic [3:0] ST_PAUSE_IR = 4'd13;

  logic       clk;
  logic       rst_n;
  logic       tms;
  logic       tdi;
  logic       tdo;
  logic       tdo_en;
  logic [4:0] ir_value;
  logic [3:0] fsm_state;

  scr1_tapc_fsm_ctrl_if dr_bus ();

  scr1_tapc_fsm_ctrl dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .tms       (tms),
    .tdi       (tdi),
    .tdo       (tdo),
    .tdo_en    (tdo_en),
    .ir_value  (ir_value),
    .fsm_state (fsm_state),
    .dr_bus    (dr_bus)
  );

  // ---------------------------------------------------------------- clock/reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int   n_checks = 0;
  int   n_fail   = 0;
  int   cap_cnt  = 0;
  int   upd_cnt  = 0;
  logic [0:0] exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------- monitor / scoreboard
  // tdo changes on the falling edge; it is sampled on the rising edge.
  always @(posedge clk) begin
    if (rst_n && tdo_en) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL tdo_unexpected: got %0b expected no output at %0t", tdo, $time);
      end else begin
        logic [0:0] e;
        e = exp_q.pop_front();
        check("tdo", {31'b0, tdo}, {31'b0, e});
      end
    end
  end

  always @(negedge clk) begin
    if (dr_bus.dr_capture) cap_cnt++;
    if (dr_bus.dr_update)  upd_cnt++;
  end

  // ---------------------------------------------------------------- driver tasks
  // Inputs change 1 ns after the rising edge and are sampled on the next one.
  task automatic tick(input logic t_ms, input logic t_di);
    tms = t_ms;
    tdi = t_di;
    @(posedge clk);
    #1;
  endtask

  // From RTI: scan op into IR (LSB first), return to RTI.
  task automatic ir_scan(input logic [4:0] op);
    logic [4:0] cap;
    cap = 5'b00001;
    tick(1'b1, 1'b0);
    tick(1'b1, 1'b0);
    tick(1'b0, 1'b0);
    tick(1'b0, 1'b0);
    for (int i = 0; i < 5; i++) begin
      exp_q.push_back(cap[i]);
      tick(i == 4, op[i]);
    end
    tick(1'b1, 1'b0);
    tick(1'b0, 1'b0);
    check("ir_value_after_update", {27'b0, ir_value}, {27'b0, op});
  endtask

  // From RTI: n-bit DR scan, return to RTI.
  task automatic dr_scan(input int n, input logic [31:0] tdi_bits,
                         input logic [31:0] dr_bits, input logic [31:0] exp_bits);
    tick(1'b1, 1'b0);
    tick(1'b0, 1'b0);
    check("dr_capture", {31'b0, dr_bus.dr_capture}, 32'd1);
    tick(1'b0, 1'b0);
    for (int i = 0; i < n; i++) begin
      dr_bus.dr_tdo = {3{dr_bits[i]}};
      exp_q.push_back(exp_bits[i]);
      check("dr_shift", {31'b0, dr_bus.dr_shift}, 32'd1);
      tick(i == n - 1, tdi_bits[i]);
    end
    check("dr_shift_off", {31'b0, dr_bus.dr_shift}, 32'd0);
    tick(1'b1, 1'b0);
    check("dr_update", {31'b0, dr_bus.dr_update}, 32'd1);
    tick(1'b0, 1'b0);
    check("dr_update_off", {31'b0, dr_bus.dr_update}, 32'd0);
  endtask

  task automatic shift_dr_bit(input logic b, input logic last);
    dr_bus.dr_tdo = {3{b}};
    exp_q.push_back(b);
    tick(last, 1'b0);
  endtask

  // ---------------------------------------------------------------- stimulus
  initial begin
    int cap0;
    int upd0;
    rst_n = 1'b0;
    tms   = 1'b1;
    tdi   = 1'b0;
    dr_bus.dr_tdo = 3'b000;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    tick(1'b1, 1'b0);

    // Reset state
    check("rst_state",     {28'b0, fsm_state}, {28'b0, ST_TLR});
    check("rst_ir_value",  {27'b0, ir_value}, 32'h01);
    check("rst_tdo_en",    {31'b0, tdo_en}, 32'd0);
    check("rst_tdo",       {31'b0, tdo}, 32'd0);
    check("rst_fsm_reset", {31'b0, dr_bus.fsm_reset}, 32'd1);
    check("rst_dr_select", {29'b0, dr_bus.dr_select}, 32'b001);
    tick(1'b0, 1'b0);

    // IDCODE DR: 32 shift cycles, tdo follows dr_tdo[0]
    dr_scan(32, 32'h0, 32'hDEADBEEF, 32'hDEADBEEF);

    // Instruction decode
    ir_scan(5'h11);
    check("sel_dmi", {29'b0, dr_bus.dr_select}, 32'b100);
    ir_scan(5'h10);
    check("sel_dtmcs", {29'b0, dr_bus.dr_select}, 32'b010);
    ir_scan(5'h05);
    check("sel_unknown", {29'b0, dr_bus.dr_select}, 32'b000);
    ir_scan(5'h1F);
    check("sel_bypass", {29'b0, dr_bus.dr_select}, 32'b000);

    // Bypass: tdi 1,0,1,1 -> tdo 0,1,0,1; dr_tdo held high must not leak
    dr_scan(4, 32'b1101, 32'hFFFFFFFF, 32'b1010);

    // Pause and resume without recapture
    ir_scan(5'h01);
    check("sel_idcode", {29'b0, dr_bus.dr_select}, 32'b001);
    cap0 = cap_cnt;
    upd0 = upd_cnt;
    tick(1'b1, 1'b0);
    tick(1'b0, 1'b0);
    tick(1'b0, 1'b0);
    shift_dr_bit(1'b1, 1'b0);
    shift_dr_bit(1'b0, 1'b0);
    shift_dr_bit(1'b1, 1'b1);
    tick(1'b0, 1'b0);
    tick(1'b0, 1'b0);
    tick(1'b0, 1'b0);
    tick(1'b1, 1'b0);
    tick(1'b0, 1'b0);
    check("resume_state", {28'b0, fsm_state}, {28'b0, ST_SH_DR});
    check("pause_capture_cnt", cap_cnt, cap0 + 1);
    check("pause_update_cnt", upd_cnt, upd0);
    shift_dr_bit(1'b0, 1'b0);
    shift_dr_bit(1'b1, 1'b1);
    tick(1'b1, 1'b0);
    tick(1'b0, 1'b0);
    check("final_update_cnt", upd_cnt, upd0 + 1);
    check("final_capture_cnt", cap_cnt, cap0 + 1);

    // Five tms=1 from Pause-IR reach TLR
    ir_scan(5'h1F);
    tick(1'b1, 1'b0);
    tick(1'b1, 1'b0);
    tick(1'b0, 1'b0);
    tick(1'b0, 1'b0);
    exp_q.push_back(1'b1);
    tick(1'b1, 1'b1);
    tick(1'b0, 1'b0);
    check("pause_ir_state", {28'b0, fsm_state}, {28'b0, ST_PAUSE_IR});
    repeat (5) tick(1'b1, 1'b0);
    check("tms5_state", {28'b0, fsm_state}, {28'b0, ST_TLR});
    check("tms5_fsm_reset", {31'b0, dr_bus.fsm_reset}, 32'd1);
    tick(1'b1, 1'b0);
    check("tms5_ir_value", {27'b0, ir_value}, 32'h01);
    check("tms5_dr_select", {29'b0, dr_bus.dr_select}, 32'b001);
    tick(1'b0, 1'b0);

    // Reset in the middle of Shift-IR
    ir_scan(5'h11);
    tick(1'b1, 1'b0);
    tick(1'b1, 1'b0);
    tick(1'b0, 1'b0);
    tick(1'b0, 1'b0);
    check("mid_ir_state", {28'b0, fsm_state}, {28'b0, ST_SH_IR});
    exp_q.push_back(1'b1);
    tick(1'b0, 1'b1);
    exp_q.push_back(1'b0);
    tick(1'b0, 1'b1);
    check("mid_ir_tdo_en", {31'b0, tdo_en}, 32'd1);
    rst_n = 1'b0;
    #1;
    check("mid_rst_state",     {28'b0, fsm_state}, {28'b0, ST_TLR});
    check("mid_rst_ir_value",  {27'b0, ir_value}, 32'h01);
    check("mid_rst_tdo_en",    {31'b0, tdo_en}, 32'd0);
    check("mid_rst_dr_select", {29'b0, dr_bus.dr_select}, 32'b001);
    tms = 1'b1;
    #1;
    rst_n = 1'b1;
    tick(1'b1, 1'b0);
    tick(1'b1, 1'b0);
    check("post_rst_ir_value", {27'b0, ir_value}, 32'h01);
    check("post_rst_state",    {28'b0, fsm_state}, {28'b0, ST_TLR});

    repeat (3) tick(1'b1, 1'b0);
    check("scoreboard_drained", exp_q.size(), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Time bound on the whole run
  initial begin
    #200000;
    n_checks++;
    n_fail++;
    $display("FAIL watchdog: got timeout expected completion");
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
